// File: rtl/lcd_frame_builder_if.sv
// lcd_frame_builder_if: bundles the clock-core fields, user controls and the
// LCD-side frame outputs of lcd_frame_builder.
//   master : drives time fields/controls, observes frame, backlight, weekday
//   slave  : the frame builder itself
interface lcd_frame_builder_if;
   logic         adjust_week;
   logic         add_week;
   logic         bl;
   logic         h12_mode;
   logic [6:0]   second;
   logic [6:0]   minute;
   logic [5:0]   hour;
   logic [5:0]   day;
   logic [4:0]   month;
   logic [7:0]   year_l;
   logic [7:0]   year_h;
   logic [255:0] data_in;
   logic         bl_en;
   logic [2:0]   week;
   logic         frame_update;

   modport master (
      output adjust_week, add_week, bl, h12_mode,
      output second, minute, hour, day, month, year_l, year_h,
      input  data_in, bl_en, week, frame_update
   );

   modport slave (
      input  adjust_week, add_week, bl, h12_mode,
      input  second, minute, hour, day, month, year_l, year_h,
      output data_in, bl_en, week, frame_update
   );
endinterface

// File: rtl/lcd_frame_builder.sv
// lcd_frame_builder: formats BCD calendar/time fields into the 32-char LCD
// frame, tracks the weekday, runs the backlight timer and flags frame changes.
//   CLOCK_50 : system clock
//   rst      : synchronous active-high reset
//   lf       : slave side of lcd_frame_builder_if (time fields, controls,
//              data_in frame, bl_en, week, frame_update)
module lcd_frame_builder #(
   parameter int unsigned BL_TIMEOUT_LOG2 = 27,
   parameter int unsigned BLINK_LOG2      = 24,
   parameter int unsigned SHOW_SECONDS    = 1,
   parameter int unsigned WEEK_RESET      = 0
) (
   input logic              CLOCK_50,
   input logic              rst,
   lcd_frame_builder_if.slave lf
);
   localparam int unsigned BL_W = BL_TIMEOUT_LOG2;
   localparam int unsigned BK_W = BLINK_LOG2 + 1;
   localparam logic [255:0] BLANK = {32{8'h20}};

   typedef enum logic [1:0] {ST_OFF, ST_TIMED, ST_ADJUST} bl_state_e;

   bl_state_e     state_q, state_d;
   logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
   logic [BK_W-1:0] blink_q, blink_d;
   logic          bl_en_q, bl_en_d;
   logic [2:0]    week_q, week_d;
   logic          add_week_prev_q;
   logic [5:0]    hour_prev_q;
   logic [255:0]  data_in_q, frame_d;
   logic          frame_update_q, frame_update_d;

   function automatic logic [7:0] dig(input logic [3:0] n);
      return {4'h3, n};
   endfunction

   // Nine-char, space-padded weekday names, first char in the top byte
   function automatic logic [71:0] week_name(input logic [2:0] w);
      case (w)
         3'd0:    return "Sunday   ";
         3'd1:    return "Monday   ";
         3'd2:    return "Tuesday  ";
         3'd3:    return "Wednesday";
         3'd4:    return "Thursday ";
         3'd5:    return "Friday   ";
         3'd6:    return "Saturday ";
         default: return "         ";
      endcase
   endfunction

   // Frame assembly
   logic [4:0]  hour_bin, hour_disp;
   logic [3:0]  hh_tens, hh_units;
   logic [71:0] name;
   always_comb begin
      frame_d  = BLANK;
      hour_bin = 5'(lf.hour[5:4]) * 5'd10 + 5'(lf.hour[3:0]);
      if (hour_bin == 5'd0)       hour_disp = 5'd12;
      else if (hour_bin > 5'd12)  hour_disp = hour_bin - 5'd12;
      else                        hour_disp = hour_bin;
      if (lf.h12_mode) begin
         hh_tens  = (hour_disp >= 5'd10) ? 4'd1 : 4'd0;
         hh_units = 4'((hour_disp >= 5'd10) ? hour_disp - 5'd10 : hour_disp);
      end else begin
         hh_tens  = {2'd0, lf.hour[5:4]};
         hh_units = lf.hour[3:0];
      end
      name = week_name(week_q);

      frame_d[8*0  +: 8] = dig(lf.year_h[7:4]);
      frame_d[8*1  +: 8] = dig(lf.year_h[3:0]);
      frame_d[8*2  +: 8] = dig(lf.year_l[7:4]);
      frame_d[8*3  +: 8] = dig(lf.year_l[3:0]);
      frame_d[8*4  +: 8] = 8'h2F;
      frame_d[8*5  +: 8] = dig({3'd0, lf.month[4]});
      frame_d[8*6  +: 8] = dig(lf.month[3:0]);
      frame_d[8*7  +: 8] = 8'h2F;
      frame_d[8*8  +: 8] = dig({2'd0, lf.day[5:4]});
      frame_d[8*9  +: 8] = dig(lf.day[3:0]);
      frame_d[8*11 +: 8] = dig(hh_tens);
      frame_d[8*12 +: 8] = dig(hh_units);
      frame_d[8*13 +: 8] = lf.second[0] ? 8'h20 : 8'h3A;
      frame_d[8*14 +: 8] = dig({1'b0, lf.minute[6:4]});
      frame_d[8*15 +: 8] = dig(lf.minute[3:0]);
      for (int i = 0; i < 9; i++) frame_d[8*(16+i) +: 8] = name[8*(8-i) +: 8];
      if (SHOW_SECONDS != 0) begin
         frame_d[8*28 +: 8] = dig({1'b0, lf.second[6:4]});
         frame_d[8*29 +: 8] = dig(lf.second[3:0]);
      end
      if (lf.h12_mode) begin
         frame_d[8*30 +: 8] = (hour_bin >= 5'd12) ? 8'h50 : 8'h41;
         frame_d[8*31 +: 8] = 8'h4D;
      end
      frame_update_d = (frame_d != data_in_q);
   end

   // Weekday: manual edges while adjusting, midnight rollover otherwise
   always_comb begin
      week_d = week_q;
      if ((lf.adjust_week && lf.add_week && !add_week_prev_q) ||
          (!lf.adjust_week && hour_prev_q != 6'h00 && lf.hour == 6'h00))
         week_d = (week_q == 3'd6) ? 3'd0 : week_q + 3'd1;
   end

   // Backlight FSM next state; adjust mode overrides everything
   always_comb begin
      state_d  = state_q;
      bl_cnt_d = bl_cnt_q;
      blink_d  = blink_q + BK_W'(1);
      case (state_q)
         ST_OFF: begin
            if (lf.bl) begin
               state_d  = ST_TIMED;
               bl_cnt_d = '0;
            end
         end
         ST_TIMED: begin
            if (lf.bl)            bl_cnt_d = '0;
            else if (&bl_cnt_q)   state_d  = ST_OFF;
            else                  bl_cnt_d = bl_cnt_q + BL_W'(1);
         end
         ST_ADJUST: begin
            state_d  = ST_TIMED;
            bl_cnt_d = '0;
         end
         default: state_d = ST_OFF;
      endcase
      if (lf.adjust_week) state_d = ST_ADJUST;
      bl_en_d = (state_d == ST_TIMED) ||
                (state_d == ST_ADJUST && blink_d[BLINK_LOG2]);
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state_q         <= ST_OFF;
         bl_cnt_q        <= '0;
         blink_q         <= '0;
         bl_en_q         <= 1'b0;
         week_q          <= 3'(WEEK_RESET);
         add_week_prev_q <= 1'b1;
         hour_prev_q     <= 6'h00;
         data_in_q       <= BLANK;
         frame_update_q  <= 1'b0;
      end else begin
         state_q         <= state_d;
         bl_cnt_q        <= bl_cnt_d;
         blink_q         <= blink_d;
         bl_en_q         <= bl_en_d;
         week_q          <= week_d;
         add_week_prev_q <= lf.add_week;
         hour_prev_q     <= lf.hour;
         data_in_q       <= frame_d;
         frame_update_q  <= frame_update_d;
      end
   end

   assign lf.data_in      = data_in_q;
   assign lf.bl_en        = bl_en_q;
   assign lf.week         = week_q;
   assign lf.frame_update = frame_update_q;
endmodule

// File: tb/tb_lcd_frame_builder.sv
// tb_lcd_frame_builder: directed bench for lcd_frame_builder with a short
// backlight timeout (16 cycles) and fast blink (period 8).
module tb_lcd_frame_builder;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int unsigned cyc;

   lcd_frame_builder_if lf ();

   lcd_frame_builder #(
      .BL_TIMEOUT_LOG2(4),
      .BLINK_LOG2     (2),
      .SHOW_SECONDS   (1),
      .WEEK_RESET     (0)
   ) dut (
      .CLOCK_50(clk),
      .rst     (rst),
      .lf      (lf.slave)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Edges since the last reset; the blink counter must match it
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   localparam logic [255:0] BLANK = {32{8'h20}};

   function automatic logic [255:0] mk(input logic [127:0] l1, input logic [127:0] l2);
      logic [255:0] s;
      logic [255:0] r;
      s = {l1, l2};
      for (int k = 0; k < 32; k++) r[8*k +: 8] = s[8*(31-k) +: 8];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      lf.adjust_week = 1'b0; lf.add_week = 1'b0; lf.bl = 1'b0; lf.h12_mode = 1'b0;
      lf.second = 7'h00; lf.minute = 7'h00; lf.hour = 6'h00; lf.day = 6'h00;
      lf.month = 5'h00; lf.year_l = 8'h00; lf.year_h = 8'h00;
      step(); step();
      chk("reset_data", lf.data_in, BLANK);
      chk("reset_bl_en", 256'(lf.bl_en), 256'(1'b0));
      chk("reset_week", 256'(lf.week), 256'(3'd0));
      chk("reset_fu", 256'(lf.frame_update), 256'(1'b0));

      // First frame after reset
      rst = 1'b0;
      lf.year_h = 8'h20; lf.year_l = 8'h24; lf.month = 5'h03; lf.day = 6'h15;
      lf.hour = 6'h09; lf.minute = 7'h05; lf.second = 7'h00;
      step();
      chk("frame_first", lf.data_in, mk("2024/03/15 09:05", "Sunday      00  "));
      chk("fu_first", 256'(lf.frame_update), 256'(1'b1));
      step();
      chk("fu_hold", 256'(lf.frame_update), 256'(1'b0));

      // Colon blink with seconds
      lf.second = 7'h01;
      step();
      chk("frame_sec1", lf.data_in, mk("2024/03/15 09 05", "Sunday      01  "));
      chk("fu_sec1", 256'(lf.frame_update), 256'(1'b1));
      lf.second = 7'h00;
      step();
      chk("frame_sec0", lf.data_in, mk("2024/03/15 09:05", "Sunday      00  "));
      chk("fu_sec0", 256'(lf.frame_update), 256'(1'b1));
      step();
      chk("fu_sec_idle", 256'(lf.frame_update), 256'(1'b0));

      // 12-hour mode under adjust (midnight must not advance the weekday)
      lf.adjust_week = 1'b1; lf.h12_mode = 1'b1; lf.hour = 6'h00;
      step();
      chk("h12_00", lf.data_in, mk("2024/03/15 12:05", "Sunday      00AM"));
      chk("week_adj_midnight", 256'(lf.week), 256'(3'd0));
      lf.hour = 6'h13;
      step();
      chk("h12_13", lf.data_in, mk("2024/03/15 01:05", "Sunday      00PM"));
      lf.hour = 6'h23;
      step();
      chk("h12_23", lf.data_in, mk("2024/03/15 11:05", "Sunday      00PM"));

      // Eight manual increments: 0 -> ... -> 6 -> 0 -> 1
      for (int p = 1; p <= 8; p++) begin
         lf.add_week = 1'b1;
         step();
         lf.add_week = 1'b0;
         if (p == 6) chk("week_p6", 256'(lf.week), 256'(3'd6));
         if (p == 7) chk("week_wrap", 256'(lf.week), 256'(3'd0));
         step();
      end
      chk("week_p8", 256'(lf.week), 256'(3'd1));
      chk("frame_monday", lf.data_in, mk("2024/03/15 11:05", "Monday      00PM"));
      lf.add_week = 1'b1;
      lf.adjust_week = 1'b0;
      step();
      chk("add_ignored", 256'(lf.week), 256'(3'd1));
      lf.add_week = 1'b0;

      // Midnight rollover in normal mode
      lf.h12_mode = 1'b0;
      step();
      lf.hour = 6'h00;
      step();
      chk("week_rollover", 256'(lf.week), 256'(3'd2));
      chk("frame_roll_old_name", lf.data_in, mk("2024/03/15 00:05", "Monday      00  "));
      step();
      chk("frame_tuesday", lf.data_in, mk("2024/03/15 00:05", "Tuesday     00  "));

      // Let the post-adjust timer expire
      repeat (20) step();
      chk("bl_idle_off", 256'(lf.bl_en), 256'(1'b0));

      // Single bl pulse: 16 cycles on
      lf.bl = 1'b1;
      step();
      lf.bl = 1'b0;
      chk("bl_rise", 256'(lf.bl_en), 256'(1'b1));
      repeat (15) step();
      chk("bl_last_on", 256'(lf.bl_en), 256'(1'b1));
      step();
      chk("bl_timeout", 256'(lf.bl_en), 256'(1'b0));

      // Retrigger at cycle 10
      lf.bl = 1'b1;
      step();
      lf.bl = 1'b0;
      repeat (9) step();
      chk("bl_pre_retrig", 256'(lf.bl_en), 256'(1'b1));
      lf.bl = 1'b1;
      step();
      lf.bl = 1'b0;
      repeat (15) step();
      chk("bl_retrig_on", 256'(lf.bl_en), 256'(1'b1));
      step();
      chk("bl_retrig_off", 256'(lf.bl_en), 256'(1'b0));

      // Adjust-mode blink follows bit 2 of the free-running counter
      lf.adjust_week = 1'b1;
      step();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("blink_%0d", i), 256'(lf.bl_en), 256'((cyc >> 2) & 1));
         step();
      end

      // Reset mid-adjust
      rst = 1'b1;
      step();
      chk("rst_adj_data", lf.data_in, BLANK);
      chk("rst_adj_week", 256'(lf.week), 256'(3'd0));
      chk("rst_adj_bl", 256'(lf.bl_en), 256'(1'b0));
      rst = 1'b0;
      step();
      chk("rst_adj_resume", lf.data_in, mk("2024/03/15 00:05", "Sunday      00  "));

      // Reset mid-timed
      lf.adjust_week = 1'b0;
      lf.bl = 1'b1;
      step();
      lf.bl = 1'b0;
      step();
      chk("timed_on", 256'(lf.bl_en), 256'(1'b1));
      rst = 1'b1;
      step();
      chk("rst_timed_bl", 256'(lf.bl_en), 256'(1'b0));
      chk("rst_timed_data", lf.data_in, BLANK);
      rst = 1'b0;
      step();
      chk("rst_timed_stay_off", 256'(lf.bl_en), 256'(1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
